stretch_arbiter: RTL

- Shares one pulse-stretch timer among NUM_CH event sources, such as lock-loss and out-of-range flags from the PLL frequency-range logic.
- Each source's rising edge is latched as a pending request.
- Pending requests are granted round-robin, one at a time.
- Each grant produces one stretched pulse on pulse_out, tagged with the channel ID, followed by a mandatory low gap, so slow indicator and readout logic can see every event.

---
 rtl/stretch_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/stretch_arbiter.sv
// Shares one pulse-stretch timer among NUM_CH edge-detected event sources.
// Pending events are granted round-robin; each grant yields one tagged stretched pulse plus a low gap.
module stretch_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int CNT_W   = 8,
    parameter int GAP_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] event_in,
    input  logic [CNT_W-1:0]  cfg_len,
    output logic              pulse_out,
    output logic [CH_W-1:0]   active_ch,
    output logic [NUM_CH-1:0] pending,
    output logic              busy,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int GAP_W    = (GAP_LEN < 2) ? 1 : $clog2(GAP_LEN + 1);
    localparam int DROP_MAX = (1 << CNT_W) - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STRETCH,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] rise, grant_mask, drop_mask;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   active_ch_q, active_ch_d;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_any, grant_vld;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              pulse_q, pulse_d;
    logic              busy_q, busy_d;
    int                drop_num;
    int                drop_sum;

    // Round-robin search: offsets are walked from farthest to nearest so the
    // nearest pending channel after the pointer is the last one written.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (pending_q[i] && (i == (int'(ptr_q) + k) % NUM_CH)) begin
                    grant_any = 1'b1;
                    grant_idx = CH_W'(i);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        active_ch_d = active_ch_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        pulse_d     = pulse_q;
        busy_d      = busy_q;
        grant_vld   = 1'b0;

        case (state_q)
            S_IDLE: begin
                pulse_d = 1'b0;
                busy_d  = 1'b0;
                if (grant_any) begin
                    grant_vld   = 1'b1;
                    ptr_d       = grant_idx;
                    active_ch_d = grant_idx;
                    len_d       = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
                    cnt_d       = CNT_W'(1);
                    pulse_d     = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = S_STRETCH;
                end
            end
            S_STRETCH: begin
                if (cnt_q == len_q) begin
                    pulse_d = 1'b0;
                    if (GAP_LEN == 0) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        gap_d   = GAP_W'(1);
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                pulse_d = 1'b0;
                if (gap_q == GAP_W'(GAP_LEN)) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                pulse_d = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // A rise on the granted channel re-arms it (set wins) and is not a drop.
    always_comb begin
        rise       = event_in & ~prev_q;
        grant_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            grant_mask[i] = grant_vld && (grant_idx == CH_W'(i));
        end
        pending_d = (pending_q & ~grant_mask) | rise;
        drop_mask = rise & pending_q & ~grant_mask;
        drop_num  = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            drop_num = drop_num + int'(drop_mask[i]);
        end
        drop_sum = int'(drop_q) + drop_num;
        drop_d   = (drop_sum > DROP_MAX) ? CNT_W'(DROP_MAX) : CNT_W'(drop_sum);
    end

    // Edge detector starts all ones so levels held through reset are not events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            prev_q      <= '1;
            pending_q   <= '0;
            ptr_q       <= CH_W'(NUM_CH - 1);
            active_ch_q <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            pulse_q     <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= event_in;
            pending_q   <= pending_d;
            ptr_q       <= ptr_d;
            active_ch_q <= active_ch_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            pulse_q     <= pulse_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
        end
    end

    assign pulse_out = pulse_q;
    assign active_ch = active_ch_q;
    assign pending   = pending_q;
    assign busy      = busy_q;
    assign drop_cnt  = drop_q;

endmodule
